// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU, its unified memory and the loader programs.
package cpu_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 4;
  localparam int RES_ADDR  = 63;
  localparam int RES_DEPTH = 4;

  // Memory controller phases: host loads the program, then the core runs it.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Core opcodes, shared so loader test programs use the same encodings as the core.
  localparam logic [DATA_W-1:0] ADD    = 4'd0;
  localparam logic [DATA_W-1:0] ADDMEM = 4'd1;
  localparam logic [DATA_W-1:0] SUB    = 4'd2;
  localparam logic [DATA_W-1:0] SUBMEM = 4'd3;
  localparam logic [DATA_W-1:0] MUL    = 4'd4;
  localparam logic [DATA_W-1:0] MULMEM = 4'd5;
  localparam logic [DATA_W-1:0] DIV    = 4'd6;
  localparam logic [DATA_W-1:0] DIVMEM = 4'd7;

endpackage

// File: rtl/cpu_memory_if.sv
// Bus bundle between the host/core side (master) and the unified memory (slave).
interface cpu_memory_if #(
  parameter int ADDR_W    = cpu_pkg::ADDR_W,
  parameter int DATA_W    = cpu_pkg::DATA_W,
  parameter int RES_DEPTH = cpu_pkg::RES_DEPTH
) ();

  localparam int CNT_W = $clog2(RES_DEPTH) + 1;

  // Host load stream
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              load_start;
  // Core access
  logic              cpu_hold;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rw;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  // Result drain
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic [CNT_W-1:0]  res_count;
  logic              res_overflow;

  modport master (
    output load_valid, load_data, load_done, load_start,
    output cpu_addr, cpu_rw, cpu_wdata, res_ready,
    input  load_ready, cpu_hold, cpu_rdata,
    input  res_valid, res_data, res_count, res_overflow
  );

  modport slave (
    input  load_valid, load_data, load_done, load_start,
    input  cpu_addr, cpu_rw, cpu_wdata, res_ready,
    output load_ready, cpu_hold, cpu_rdata,
    output res_valid, res_data, res_count, res_overflow
  );

endinterface

// File: rtl/cpu_memory_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count and sticky overflow flag.
module result_fifo #(
  parameter int DATA_W    = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop_req,
  output logic                           valid,
  output logic [DATA_W-1:0]              data,
  output logic [$clog2(RES_DEPTH):0]     count,
  output logic                           overflow
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] store [RES_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              full;
  logic              do_pop;
  logic              do_push;

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(RES_DEPTH));
  assign do_pop  = pop_req & valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign data    = store[rd_ptr];

  // Pointer, count and overflow bookkeeping; flush behaves like a local reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

  // Entry storage.
  // NOTE: storage arrays carry no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cpu_memory.sv
// Unified program/data memory for the 4-bit core with host load phase and result FIFO.
module cpu_memory #(
  parameter int ADDR_W    = cpu_pkg::ADDR_W,
  parameter int DATA_W    = cpu_pkg::DATA_W,
  parameter int RES_ADDR  = cpu_pkg::RES_ADDR,
  parameter int RES_DEPTH = cpu_pkg::RES_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  cpu_memory_if.slave  bus
);

  import cpu_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic              load_accept;
  logic              cpu_we;
  logic              res_push;
  logic              res_flush;
  logic              load_ready;
  logic              cpu_hold;
  logic [DATA_W-1:0] cpu_rdata;

  // Phase decode: next state plus the strobes each phase allows.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next  = state;
    load_ready  = 1'b0;
    cpu_hold    = 1'b0;
    load_accept = 1'b0;
    cpu_we      = 1'b0;
    res_push    = 1'b0;
    res_flush   = 1'b0;
    case (state)
      LOAD: begin
        load_ready  = 1'b1;
        cpu_hold    = 1'b1;
        load_accept = bus.load_valid;
        // A beat at the last address wraps the pointer and hands over to the core.
        if (bus.load_done || (load_accept && ptr == '1)) state_next = RUN;
      end
      RUN: begin
        cpu_we   = bus.cpu_rw;
        res_push = bus.cpu_rw && (bus.cpu_addr == ADDR_W'(RES_ADDR));
        if (bus.load_start) begin
          state_next = LOAD;
          res_flush  = 1'b1;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // State register and load pointer.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      ptr   <= '0;
    end else begin
      state <= state_next;
      if (load_accept)    ptr <= ptr + 1'b1;
      else if (res_flush) ptr <= '0;
    end
  end

  // Memory write port: loader beats in LOAD, core writes in RUN; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_accept) mem[ptr]          <= bus.load_data;
      else if (cpu_we) mem[bus.cpu_addr] <= bus.cpu_wdata;
    end
  end

  // Zero-latency read for the core, which samples data on the edge that drives the address.
  always_comb begin
    cpu_rdata = '0;
    if (state == RUN) cpu_rdata = mem[bus.cpu_addr];
  end

  assign bus.load_ready = load_ready;
  assign bus.cpu_hold   = cpu_hold;
  assign bus.cpu_rdata  = cpu_rdata;

  result_fifo #(
    .DATA_W    (DATA_W),
    .RES_DEPTH (RES_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (res_flush),
    .push      (res_push),
    .push_data (bus.cpu_wdata),
    .pop_req   (bus.res_ready),
    .valid     (bus.res_valid),
    .data      (bus.res_data),
    .count     (bus.res_count),
    .overflow  (bus.res_overflow)
  );

endmodule
